// File: rtl/systolic_left_skew_feeder.sv
// Left-edge feeder for the systolic array: lane r delays each accepted vector by r+1 cycles.
// After the last vector of a tile, zeros drain the lanes and o_done pulses when the tile has fully left.
module systolic_left_skew_feeder #(
  parameter int PE_ARRAY_H    = 64,
  parameter int IN_DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_vld,
  output logic                     o_rdy,
  input  logic                     i_last,
  input  logic [IN_DATA_WIDTH-1:0] i_data      [0:PE_ARRAY_H-1],
  output logic [IN_DATA_WIDTH-1:0] o_left_data [0:PE_ARRAY_H-1],
  output logic                     o_lane_vld  [0:PE_ARRAY_H-1],
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int CW = $clog2(PE_ARRAY_H);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_done;
  logic            w_rdy;
  logic            w_busy;
  logic            w_acc;

  assign w_acc  = i_vld & w_rdy;
  assign o_rdy  = w_rdy;
  assign o_busy = w_busy;
  assign o_done = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_rdy  = 1'b1;
    w_busy = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_next = i_last ? S_DRAIN : S_STREAM;
        end
      end
      S_STREAM: begin
        w_busy = 1'b1;
        if (w_acc && i_last) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_rdy  = 1'b0;
        w_busy = 1'b1;
        if (r_cnt == '0) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Counter covers the H cycles needed for the last vector to exit the deepest lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_DRAIN) && (r_cnt == '0);
      if ((r_state != S_DRAIN) && (w_next == S_DRAIN)) begin
        r_cnt <= CW'(PE_ARRAY_H - 1);
      end else if ((r_state == S_DRAIN) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  for (genvar r = 0; r < PE_ARRAY_H; r++) begin : g_lane
    localparam int D = r + 1;
    logic [IN_DATA_WIDTH-1:0] r_d [0:D-1];
    logic                     r_v [0:D-1];

    // Lanes never stall: a bubble shifts in as a zero, invalid element.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < D; k++) begin
          r_d[k] <= '0;
          r_v[k] <= 1'b0;
        end
      end else begin
        r_d[0] <= w_acc ? i_data[r] : '0;
        r_v[0] <= w_acc;
        for (int k = 1; k < D; k++) begin
          r_d[k] <= r_d[k-1];
          r_v[k] <= r_v[k-1];
        end
      end
    end

    assign o_left_data[r] = r_d[D-1];
    assign o_lane_vld[r]  = r_v[D-1];
  end

endmodule

// File: tb/tb_systolic_left_skew_feeder.sv
// Bench for systolic_left_skew_feeder: directed tiles plus random traffic against a cycle-history model.
module tb_systolic_left_skew_feeder;
  localparam int H  = 4;
  localparam int W  = 8;
  localparam int NC = 2048;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_vld;
  logic         o_rdy;
  logic         i_last;
  logic [W-1:0] i_data      [0:H-1];
  logic [W-1:0] o_left_data [0:H-1];
  logic         o_lane_vld  [0:H-1];
  logic         o_busy;
  logic         o_done;

  systolic_left_skew_feeder #(.PE_ARRAY_H(H), .IN_DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .i_vld(i_vld), .o_rdy(o_rdy), .i_last(i_last),
    .i_data(i_data), .o_left_data(o_left_data), .o_lane_vld(o_lane_vld),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: what was accepted in each cycle, plus tile bookkeeping.
  logic [W-1:0] hist_d [0:NC-1][0:H-1];
  bit           hist_v [0:NC-1];
  int  cyc       = 0;
  int  base      = 0;
  int  t_last    = -1000;
  bit  streaming = 1'b0;
  bit  armed     = 1'b0;
  bit  b2b       = 1'b0;
  int  last_done = -1;

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic chkd(input string tag, input int r, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s lane=%0d cyc=%0d observed=%h expected=%h", tag, r, cyc, obs, exp_v);
    end
  endtask

  task automatic step(input bit v, input bit l, input bit rs, input logic [H*W-1:0] dp);
    bit in_drain;
    bit acc;
    int idx;
    @(negedge clk);
    in_drain = (cyc >= t_last + 1) && (cyc <= t_last + H);
    if (armed) begin
      for (int r = 0; r < H; r++) begin
        idx = cyc - r - 1;
        if (idx >= base && idx >= 0) begin
          chkd("lane_data", r, o_left_data[r], hist_d[idx][r]);
          chk1("lane_vld", o_lane_vld[r], hist_v[idx]);
        end else begin
          chkd("lane_data", r, o_left_data[r], '0);
          chk1("lane_vld", o_lane_vld[r], 1'b0);
        end
      end
      chk1("rdy", o_rdy, !in_drain);
      chk1("busy", o_busy, in_drain || streaming);
      chk1("done", o_done, cyc == t_last + H + 1);
      if (b2b && o_done === 1'b1) begin
        if (last_done >= 0) begin
          tests++;
          assert ((cyc - last_done) === 6) else begin
            fails++;
            $error("FAIL done_spacing observed=%0d expected=6", cyc - last_done);
          end
        end
        last_done = cyc;
      end
    end
    rst    = rs;
    i_vld  = v;
    i_last = l;
    for (int r = 0; r < H; r++) i_data[r] = dp[r*W +: W];
    acc = v && !in_drain && !rs;
    hist_v[cyc] = acc;
    for (int r = 0; r < H; r++) hist_d[cyc][r] = acc ? dp[r*W +: W] : '0;
    if (rs) begin
      base      = cyc + 1;
      t_last    = -1000;
      streaming = 1'b0;
      armed     = 1'b1;
    end else if (acc) begin
      if (l) begin
        t_last    = cyc;
        streaming = 1'b0;
      end else begin
        streaming = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, i[0], 1'b0, 32'hDEADBEEF);
  endtask

  initial begin
    logic [H*W-1:0] rd;
    int acc_n;
    rst = 1'b1; i_vld = 1'b0; i_last = 1'b0;
    for (int r = 0; r < H; r++) i_data[r] = '0;

    // Reset for two cycles, then idle
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    idle(3);

    // Single-vector tile: lane r carries element r
    step(1'b1, 1'b1, 1'b0, 32'h44332211);
    idle(7);

    // Three-vector stream; keep i_vld high during drain to prove nothing is taken
    step(1'b1, 1'b0, 1'b0, 32'h01010101);
    step(1'b1, 1'b0, 1'b0, 32'h02020202);
    step(1'b1, 1'b1, 1'b0, 32'h03030303);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'hEEEEEEEE);
    idle(3);

    // Bubble inside a tile (i_last high on the bubble must be ignored)
    step(1'b1, 1'b0, 1'b0, 32'hA0A0A0A0);
    step(1'b0, 1'b1, 1'b0, 32'h55555555);
    step(1'b1, 1'b1, 1'b0, 32'hA2A2A2A2);
    idle(8);

    // Reset in the middle of draining
    step(1'b1, 1'b1, 1'b0, 32'h44332211);
    idle(1);
    step(1'b0, 1'b0, 1'b1, '0);
    idle(8);

    // Back-to-back tiles with i_vld held high, last on every second accept
    b2b = 1'b1; last_done = -1; acc_n = 0;
    for (int i = 0; i < 36; i++) begin
      bit rdy_m;
      rdy_m = !((cyc >= t_last + 1) && (cyc <= t_last + H));
      step(1'b1, acc_n[0], 1'b0, {4{8'(8'h10 + i)}});
      if (rdy_m) acc_n++;
    end
    b2b = 1'b0;
    idle(6);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < H; r++) rd[r*W +: W] = 8'($urandom);
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) == 0, rd);
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
